// File: rtl/scoreboard_register_file_if.sv
// scoreboard_register_file_if: decode/writeback bundle for the scoreboard register file
// master = pipeline side (decode reads/reserves, writeback writes), slave = register file
interface scoreboard_register_file_if #(
    parameter int WIDTH         = 16,
    parameter int REGISTER_BITS = 4
);
    logic                     ready;
    logic                     write_en;
    logic [REGISTER_BITS-1:0] write_addr;
    logic [WIDTH-1:0]         write_data;
    logic                     reserve_en;
    logic [REGISTER_BITS-1:0] reserve_addr;
    logic [REGISTER_BITS-1:0] rd1_addr;
    logic [REGISTER_BITS-1:0] rd2_addr;
    logic [WIDTH-1:0]         rd1_data;
    logic [WIDTH-1:0]         rd2_data;
    logic                     rd1_valid;
    logic                     rd2_valid;

    modport master (
        input  ready, rd1_data, rd2_data, rd1_valid, rd2_valid,
        output write_en, write_addr, write_data, reserve_en, reserve_addr, rd1_addr, rd2_addr
    );

    modport slave (
        output ready, rd1_data, rd2_data, rd1_valid, rd2_valid,
        input  write_en, write_addr, write_data, reserve_en, reserve_addr, rd1_addr, rd2_addr
    );
endinterface

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file: 2R1W register file with per-register pending bits and a post-reset clear sweep.
// Optional same-cycle write-to-read bypass when SCOREBOARD_REGFILE_BYPASS_EN is defined.
module scoreboard_register_file #(
    parameter int WIDTH         = 16,
    parameter int REGISTER_BITS = 4,
    parameter bit ZERO_REG      = 1'b1
) (
    input logic clock,
    input logic reset,
    scoreboard_register_file_if.slave bus
);
    localparam int DEPTH = 1 << REGISTER_BITS;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]               state_q;
    logic [REGISTER_BITS-1:0] cnt_q;
    logic [DEPTH-1:0]         pend_q;
    logic [DEPTH-1:0]         pend_d;
    logic [WIDTH-1:0]         regs_q [DEPTH];
    logic                     run;
    logic                     w_ok;
    logic                     r_ok;

    assign run       = state_q == RUN;
    assign bus.ready = run;
    assign w_ok      = run && bus.write_en && !(ZERO_REG && bus.write_addr == '0);
    assign r_ok      = run && bus.reserve_en && !(ZERO_REG && bus.reserve_addr == '0);

    // reserve is applied after release so a same-address pair leaves the register pending
    always_comb begin
        pend_d = pend_q;
        if (w_ok) pend_d[bus.write_addr] = 1'b0;
        if (r_ok) pend_d[bus.reserve_addr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else if (state_q == CLEAR) begin
            regs_q[cnt_q] <= '0;
            cnt_q         <= cnt_q + 1'b1;
            if (&cnt_q) state_q <= RUN;
        end else begin
            if (w_ok) regs_q[bus.write_addr] <= bus.write_data;
            pend_q <= pend_d;
        end
    end

    logic [REGISTER_BITS-1:0] ra   [2];
    logic [WIDTH-1:0]         rdat [2];
    logic                     rval [2];

    assign ra[0]         = bus.rd1_addr;
    assign ra[1]         = bus.rd2_addr;
    assign bus.rd1_data  = rdat[0];
    assign bus.rd2_data  = rdat[1];
    assign bus.rd1_valid = rval[0];
    assign bus.rd2_valid = rval[1];

    for (genvar g = 0; g < 2; g++) begin : g_rd
        logic zero;
        logic byp;
        assign zero = ZERO_REG && ra[g] == '0;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        assign byp = w_ok && bus.write_addr == ra[g];
`else
        assign byp = 1'b0;
`endif
        assign rdat[g] = (!run || zero) ? '0 : byp ? bus.write_data : regs_q[ra[g]];
        assign rval[g] = run && (zero || (byp ? !(r_ok && bus.reserve_addr == ra[g]) : !pend_q[ra[g]]));
    end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb_scoreboard_register_file: directed plus random checks against an array-based reference model.
module tb_scoreboard_register_file;
    logic clock = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;

    scoreboard_register_file_if #(.WIDTH(16), .REGISTER_BITS(4)) bus ();
    scoreboard_register_file dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    logic [15:0] mem [16];
    bit          pend [16];
    bit          rdy;
    int          swept;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_data(input logic [3:0] a);
        if (!rdy || a == 0) return 16'h0;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        if (bus.write_en && bus.write_addr == a) return bus.write_data;
`endif
        return mem[a];
    endfunction

    function automatic bit exp_valid(input logic [3:0] a);
        if (!rdy) return 1'b0;
        if (a == 0) return 1'b1;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        if (bus.write_en && bus.write_addr == a) return !(bus.reserve_en && bus.reserve_addr == a);
`endif
        return !pend[a];
    endfunction

    task automatic reads(input string tag);
        #1;
        check({tag, ".ready"}, 32'(bus.ready), 32'(rdy));
        check({tag, ".rd1_data"}, 32'(bus.rd1_data), 32'(exp_data(bus.rd1_addr)));
        check({tag, ".rd1_valid"}, 32'(bus.rd1_valid), 32'(exp_valid(bus.rd1_addr)));
        check({tag, ".rd2_data"}, 32'(bus.rd2_data), 32'(exp_data(bus.rd2_addr)));
        check({tag, ".rd2_valid"}, 32'(bus.rd2_valid), 32'(exp_valid(bus.rd2_addr)));
    endtask

    task automatic tick;
        if (reset) begin
            rdy = 0;
            swept = 0;
            foreach (pend[i]) pend[i] = 0;
        end else if (!rdy) begin
            mem[swept] = 16'h0;
            swept++;
            rdy = swept == 16;
        end else begin
            if (bus.write_en && bus.write_addr != 0) begin
                mem[bus.write_addr] = bus.write_data;
                pend[bus.write_addr] = 0;
            end
            if (bus.reserve_en && bus.reserve_addr != 0) pend[bus.reserve_addr] = 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                         input bit re, input logic [3:0] rsa, input logic [3:0] a1, input logic [3:0] a2);
        bus.write_en = we;
        bus.write_addr = wa;
        bus.write_data = wd;
        bus.reserve_en = re;
        bus.reserve_addr = rsa;
        bus.rd1_addr = a1;
        bus.rd2_addr = a2;
    endtask

    initial begin
        rdy = 0;
        swept = 0;
        foreach (mem[i]) mem[i] = 'x;
        foreach (pend[i]) pend[i] = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 4'd3, 4'd5);
        tick();
        reset = 1'b0;
        reads("reset");
        // partial sweep, then reset again at the 7th sweep edge
        for (int i = 1; i <= 6; i++) tick();
        check("mid_sweep_ready", 32'(bus.ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 4) drive(1, 4'd2, 16'hFFFF, 1, 4'd7, 4'd2, 4'd7);
            else drive(0, 0, 0, 0, 0, 4'd2, 4'd7);
            reads("sweep");
            tick();
            check("sweep_edge_ready", 32'(bus.ready), 32'(i == 16));
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 4'(i), 4'(15 - i));
            reads("clear_all");
            check("clear_zero", 32'(bus.rd1_data), 32'd0);
            check("clear_valid", 32'(bus.rd1_valid), 32'd1);
        end
        drive(1, 4'd3, 16'hBEEF, 0, 0, 4'd1, 4'd1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd3, 4'd3);
        reads("r3");
        check("r3_value", 32'(bus.rd2_data), 32'hBEEF);
        drive(1, 4'd0, 16'h1234, 0, 0, 4'd1, 4'd1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd0, 4'd3);
        reads("r0");
        check("r0_zero", 32'(bus.rd1_data), 32'd0);
        drive(0, 0, 0, 1, 4'd5, 4'd1, 4'd1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd5, 4'd5);
        reads("r5_pend");
        check("r5_pending", 32'(bus.rd1_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            reads("r5_wait");
        end
        drive(1, 4'd5, 16'h00AA, 0, 0, 4'd1, 4'd1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd5, 4'd1);
        reads("r5_done");
        check("r5_released", 32'(bus.rd1_valid), 32'd1);
        drive(1, 4'd6, 16'h0066, 1, 4'd6, 4'd1, 4'd1);
        tick();
        drive(0, 0, 0, 0, 0, 4'd6, 4'd6);
        reads("r6_race");
        check("r6_data", 32'(bus.rd1_data), 32'h0066);
        check("r6_pending", 32'(bus.rd1_valid), 32'd0);
        drive(1, 4'd9, 16'h5555, 0, 0, 4'd9, 4'd9);
        reads("r9_same");
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        check("r9_bypass", 32'(bus.rd1_data), 32'h5555);
`else
        check("r9_old", 32'(bus.rd1_data), 32'h0);
`endif
        tick();
        drive(0, 0, 0, 0, 0, 4'd9, 4'd9);
        reads("r9_next");
        check("r9_new", 32'(bus.rd1_data), 32'h5555);
        for (int i = 0; i < 400; i++) begin
            reset = $urandom_range(0, 99) == 0;
            drive(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                  4'($urandom), 4'($urandom), 4'($urandom));
            reads("random");
            tick();
        end
        reset = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
